stack_sequencer: RTL and testbench

- Controller for the 8-bit stack pointer increment/decrement register (S) in the 2A03 core.
- Sequences 1-, 2- and 3-byte stack pushes and pulls for PHA/PHP, PLA/PLP, JSR, RTS, BRK/IRQ/NMI and RTI.
- Drives the S register's load and select controls and the stack-page memory bus, then returns pulled bytes to the core.
- In idle, passes TXS loads through to S.

---
 rtl/stack_sequencer_if.sv | 32 +++
 rtl/stack_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_stack_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_sequencer_if.sv
// Request and stack-page memory bus between the core and the stack sequencer.
// The master side is the core/memory environment; the slave side is the sequencer.
interface stack_sequencer_if;
    logic        req;
    logic [2:0]  op;
    logic [7:0]  push_b0;
    logic [7:0]  push_b1;
    logic [7:0]  push_b2;
    logic [7:0]  pull_b0;
    logic [7:0]  pull_b1;
    logic [7:0]  pull_b2;
    logic        busy;
    logic        done;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_rdy;

    modport master (
        output req, op, push_b0, push_b1, push_b2, mem_rdata, mem_rdy,
        input  pull_b0, pull_b1, pull_b2, busy, done,
        input  mem_addr, mem_we, mem_re, mem_wdata
    );

    modport slave (
        input  req, op, push_b0, push_b1, push_b2, mem_rdata, mem_rdy,
        output pull_b0, pull_b1, pull_b2, busy, done,
        output mem_addr, mem_we, mem_re, mem_wdata
    );
endinterface

// File: rtl/stack_sequencer.sv
// Stack pointer (S) sequencer: walks 1-3 byte pushes and pulls over the stack
// page, steering the external S register and returning pulled bytes.
// Pushes write at S then decrement; pulls pre-increment then read at S.
module stack_sequencer #(
    parameter logic [7:0] STACK_PAGE = 8'h01,
    parameter int         SW         = 8
) (
    input  logic                clk,
    input  logic                rst,
    stack_sequencer_if.slave    bus,
    input  logic                txs_load,
    input  logic [SW-1:0]       x_in,
    input  logic [SW-1:0]       s_in,
    output logic                s_load,
    output logic [1:0]          s_sel,
    output logic [SW-1:0]       s_data
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PUSH     = 3'd1,
        PULL_INC = 3'd2,
        PULL_RD  = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [1:0] SEL_DATA = 2'd0;
    localparam logic [1:0] SEL_INC  = 2'd1;
    localparam logic [1:0] SEL_DEC  = 2'd2;

    state_t      state_r, state_nxt_s;
    logic [1:0]  cnt_r, cnt_nxt_s;
    logic [1:0]  last_r;
    logic [7:0]  push0_r, push1_r, push2_r;
    logic [7:0]  pull0_r, pull1_r, pull2_r;
    logic        accept_s;
    logic        capture_s;
    logic [15:0] mem_addr_s;
    logic        mem_we_s, mem_re_s;
    logic [7:0]  mem_wdata_s;
    logic        busy_s, done_s;

    // Index of the final byte for a given op (N-1).
    function automatic logic [1:0] last_index(input logic [2:0] op_v);
        case (op_v)
            3'd0, 3'd3: last_index = 2'd0;
            3'd1, 3'd4: last_index = 2'd1;
            3'd2, 3'd5: last_index = 2'd2;
            default:    last_index = 2'd0;
        endcase
    endfunction

    // Latched push byte selected by the byte counter.
    function automatic logic [7:0] push_byte(input logic [1:0] idx,
                                             input logic [7:0] b0,
                                             input logic [7:0] b1,
                                             input logic [7:0] b2);
        case (idx)
            2'd0:    push_byte = b0;
            2'd1:    push_byte = b1;
            2'd2:    push_byte = b2;
            default: push_byte = 8'h00;
        endcase
    endfunction

    // Next-state and output decode; mem_rdy low freezes progress but keeps the bus driven.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        accept_s    = 1'b0;
        capture_s   = 1'b0;
        s_load      = 1'b0;
        s_sel       = SEL_DATA;
        s_data      = '0;
        mem_addr_s  = 16'h0000;
        mem_we_s    = 1'b0;
        mem_re_s    = 1'b0;
        mem_wdata_s = 8'h00;
        busy_s      = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req && (bus.op <= 3'd5)) begin
                    // A valid request takes priority over a simultaneous TXS.
                    accept_s    = 1'b1;
                    cnt_nxt_s   = 2'd0;
                    state_nxt_s = (bus.op <= 3'd2) ? PUSH : PULL_INC;
                end else if (txs_load) begin
                    s_load = 1'b1;
                    s_sel  = SEL_DATA;
                    s_data = x_in;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PUSH: begin
                busy_s      = 1'b1;
                mem_we_s    = 1'b1;
                mem_addr_s  = {STACK_PAGE, s_in};
                mem_wdata_s = push_byte(cnt_r, push0_r, push1_r, push2_r);
                if (bus.mem_rdy) begin
                    s_load    = 1'b1;
                    s_sel     = SEL_DEC;
                    cnt_nxt_s = cnt_r + 2'd1;
                    if (cnt_r == last_r) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = PUSH;
                    end
                end else begin
                    state_nxt_s = PUSH;
                end
            end
            PULL_INC: begin
                busy_s = 1'b1;
                if (bus.mem_rdy) begin
                    s_load      = 1'b1;
                    s_sel       = SEL_INC;
                    state_nxt_s = PULL_RD;
                end else begin
                    state_nxt_s = PULL_INC;
                end
            end
            PULL_RD: begin
                busy_s     = 1'b1;
                mem_re_s   = 1'b1;
                mem_addr_s = {STACK_PAGE, s_in};
                if (bus.mem_rdy) begin
                    capture_s = 1'b1;
                    cnt_nxt_s = cnt_r + 2'd1;
                    if (cnt_r == last_r) begin
                        // S already points at the last pulled byte; no further increment.
                        state_nxt_s = DONE;
                    end else begin
                        s_load      = 1'b1;
                        s_sel       = SEL_INC;
                        state_nxt_s = PULL_RD;
                    end
                end else begin
                    state_nxt_s = PULL_RD;
                end
            end
            DONE: begin
                busy_s      = 1'b1;
                done_s      = 1'b1;
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, counter, request latches and pulled-byte capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 2'd0;
            last_r  <= 2'd0;
            push0_r <= 8'h00;
            push1_r <= 8'h00;
            push2_r <= 8'h00;
            pull0_r <= 8'h00;
            pull1_r <= 8'h00;
            pull2_r <= 8'h00;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (accept_s) begin
                last_r  <= last_index(bus.op);
                push0_r <= bus.push_b0;
                push1_r <= bus.push_b1;
                push2_r <= bus.push_b2;
            end
            if (capture_s) begin
                case (cnt_r)
                    2'd0:    pull0_r <= bus.mem_rdata;
                    2'd1:    pull1_r <= bus.mem_rdata;
                    2'd2:    pull2_r <= bus.mem_rdata;
                    default: pull2_r <= pull2_r;
                endcase
            end
        end
    end

    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_we    = mem_we_s;
    assign bus.mem_re    = mem_re_s;
    assign bus.mem_wdata = mem_wdata_s;
    assign bus.busy      = busy_s;
    assign bus.done      = done_s;
    assign bus.pull_b0   = pull0_r;
    assign bus.pull_b1   = pull1_r;
    assign bus.pull_b2   = pull2_r;

endmodule

// File: tb/tb_stack_sequencer.sv
// Scoreboard bench for stack_sequencer: stimulus queues expected writes, reads,
// done events and output snapshots; a monitor compares them as the DUT responds.
module tb_stack_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stack_sequencer_if ifc();

    logic       txs_load = 1'b0;
    logic [7:0] x_in     = 8'h00;
    logic [7:0] s_reg    = 8'h00;
    logic       s_load;
    logic [1:0] s_sel;
    logic [7:0] s_data;

    stack_sequencer #(.STACK_PAGE(8'h01), .SW(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (ifc.slave),
        .txs_load (txs_load),
        .x_in     (x_in),
        .s_in     (s_reg),
        .s_load   (s_load),
        .s_sel    (s_sel),
        .s_data   (s_data)
    );

    // Model of the external S register driven by the sequencer controls.
    always @(posedge clk) begin
        if (s_load === 1'b1) begin
            case (s_sel)
                2'd0:    s_reg <= s_data;
                2'd1:    s_reg <= s_reg + 8'd1;
                2'd2:    s_reg <= s_reg - 8'd1;
                default: s_reg <= s_reg;
            endcase
        end
    end

    // Stack page memory with a backdoor preload port.
    logic [7:0] mem [0:255];
    logic       bd_we   = 1'b0;
    logic [7:0] bd_addr = 8'h00;
    logic [7:0] bd_data = 8'h00;
    always @(posedge clk) begin
        if (bd_we)
            mem[bd_addr] <= bd_data;
        else if (ifc.mem_we === 1'b1 && ifc.mem_rdy === 1'b1)
            mem[ifc.mem_addr[7:0]] <= ifc.mem_wdata;
    end
    assign ifc.mem_rdata = mem[ifc.mem_addr[7:0]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [7:0] p0; logic [7:0] p1; logic [7:0] p2; logic [7:0] s; } done_t;
    typedef struct { int cyc; logic [62:0] v; } snap_t;

    logic [23:0] exp_wr [$];
    logic [16:0] exp_rd [$];
    done_t       exp_done [$];
    snap_t       exp_snap [$];

    int   checks = 0;
    int   errors = 0;
    int   tmo_count = 0;
    logic fin = 1'b0;
    logic [7:0] pb0 = 8'h00, pb1 = 8'h00, pb2 = 8'h00;

    // Expected output vector with no memory activity and the current pull bytes.
    function automatic logic [62:0] mk(input logic sl, input logic [1:0] ss, input logic [7:0] sd,
                                       input logic bsy, input logic dn);
        return {sl, ss, sd, 16'h0000, 1'b0, 1'b0, 8'h00, pb0, pb1, pb2, bsy, dn};
    endfunction

    function automatic done_t mkd(input int c, input logic [7:0] s);
        done_t d;
        d.cyc = c; d.p0 = pb0; d.p1 = pb1; d.p2 = pb2; d.s = s;
        return d;
    endfunction

    task automatic push_snap(input logic [62:0] v);
        snap_t sn;
        sn.cyc = cyc;
        sn.v   = v;
        exp_snap.push_back(sn);
    endtask

    // Monitor: samples just after each falling edge and scores every DUT response.
    initial begin
        logic [62:0] obs;
        snap_t       sn;
        done_t       d;
        logic [23:0] w;
        logic [16:0] r;
        forever begin
            @(negedge clk);
            #1;
            obs = {s_load, s_sel, s_data, ifc.mem_addr, ifc.mem_we, ifc.mem_re, ifc.mem_wdata,
                   ifc.pull_b0, ifc.pull_b1, ifc.pull_b2, ifc.busy, ifc.done};
            while (exp_snap.size() > 0 && exp_snap[0].cyc <= cyc) begin
                sn = exp_snap.pop_front();
                checks++;
                if (sn.cyc != cyc || obs !== sn.v) begin
                    errors++;
                    $display("FAIL snapshot cyc=%0d got=%h want=%h", cyc, obs, sn.v);
                end
            end
            if ((ifc.mem_we | ifc.mem_re) === 1'b1) begin
                checks++;
                if ((ifc.mem_we & ifc.mem_re) !== 1'b0) begin
                    errors++;
                    $display("FAIL we_re_exclusive cyc=%0d got we=%b re=%b want not both", cyc, ifc.mem_we, ifc.mem_re);
                end
            end
            if (ifc.mem_we === 1'b1) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write cyc=%0d got addr=%h data=%h want none", cyc, ifc.mem_addr, ifc.mem_wdata);
                end else if (ifc.mem_rdy) begin
                    w = exp_wr.pop_front();
                    if ({ifc.mem_addr, ifc.mem_wdata, s_load, s_sel} !== {w, 1'b1, 2'd2}) begin
                        errors++;
                        $display("FAIL write cyc=%0d got addr=%h data=%h s_load=%b s_sel=%0d want %h/%h 1 2",
                                 cyc, ifc.mem_addr, ifc.mem_wdata, s_load, s_sel, w[23:8], w[7:0]);
                    end
                end else begin
                    w = exp_wr[0];
                    if ({ifc.mem_addr, ifc.mem_wdata, s_load} !== {w, 1'b0}) begin
                        errors++;
                        $display("FAIL write_stall cyc=%0d got addr=%h data=%h s_load=%b want %h/%h 0",
                                 cyc, ifc.mem_addr, ifc.mem_wdata, s_load, w[23:8], w[7:0]);
                    end
                end
            end
            if (ifc.mem_re === 1'b1) begin
                checks++;
                if (exp_rd.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_read cyc=%0d got addr=%h want none", cyc, ifc.mem_addr);
                end else if (ifc.mem_rdy) begin
                    r = exp_rd.pop_front();
                    if ({ifc.mem_addr, s_load, s_sel} !== {r[16:1], ~r[0], (r[0] ? 2'd0 : 2'd1)}) begin
                        errors++;
                        $display("FAIL read cyc=%0d got addr=%h s_load=%b s_sel=%0d want addr=%h last=%b",
                                 cyc, ifc.mem_addr, s_load, s_sel, r[16:1], r[0]);
                    end
                end else begin
                    r = exp_rd[0];
                    if ({ifc.mem_addr, s_load} !== {r[16:1], 1'b0}) begin
                        errors++;
                        $display("FAIL read_stall cyc=%0d got addr=%h s_load=%b want %h 0", cyc, ifc.mem_addr, s_load, r[16:1]);
                    end
                end
            end
            if (ifc.done === 1'b1) begin
                checks++;
                if (exp_done.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done cyc=%0d got done=1 want 0", cyc);
                end else begin
                    d = exp_done.pop_front();
                    if ({cyc, ifc.pull_b0, ifc.pull_b1, ifc.pull_b2, s_reg, s_load} !==
                        {d.cyc, d.p0, d.p1, d.p2, d.s, 1'b0}) begin
                        errors++;
                        $display("FAIL done cyc=%0d got pull=%h/%h/%h S=%h s_load=%b want cyc=%0d pull=%h/%h/%h S=%h s_load=0",
                                 cyc, ifc.pull_b0, ifc.pull_b1, ifc.pull_b2, s_reg, s_load,
                                 d.cyc, d.p0, d.p1, d.p2, d.s);
                    end
                end
            end
            if (fin) begin
                checks++;
                if (exp_wr.size() + exp_rd.size() + exp_done.size() + exp_snap.size() != 0 || tmo_count != 0) begin
                    errors++;
                    $display("FAIL drain got wr=%0d rd=%0d done=%0d snap=%0d timeouts=%0d want all 0",
                             exp_wr.size(), exp_rd.size(), exp_done.size(), exp_snap.size(), tmo_count);
                end
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    task automatic set_s(input logic [7:0] v);
        @(negedge clk);
        txs_load = 1'b1;
        x_in     = v;
        push_snap(mk(1'b1, 2'd0, v, 1'b0, 1'b0));
        @(negedge clk);
        txs_load = 1'b0;
    endtask

    task automatic bd(input logic [7:0] a, input logic [7:0] dv);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = dv;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Issue a request; returns in the cycle after acceptance.
    task automatic start(input logic [2:0] o, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, output int acc);
        @(negedge clk);
        ifc.req = 1'b1; ifc.op = o;
        ifc.push_b0 = b0; ifc.push_b1 = b1; ifc.push_b2 = b2;
        acc = cyc;
        @(negedge clk);
        ifc.req = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ifc.done === 1'b1) return;
        end
        tmo_count++;
        $display("FAIL done_timeout cyc=%0d got no done want done within %0d cycles", cyc, budget);
    endtask

    // Directed stimulus with hand-computed expectations.
    initial begin
        int acc;
        ifc.req = 1'b0; ifc.op = 3'd0;
        ifc.push_b0 = 8'h00; ifc.push_b1 = 8'h00; ifc.push_b2 = 8'h00;
        ifc.mem_rdy = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        push_snap(mk(1'b0, 2'd0, 8'h00, 1'b0, 1'b0));
        rst = 1'b0;

        // TXS pass-through in idle.
        set_s(8'h40);
        set_s(8'hFD);

        // PUSH3 (BRK) from FD.
        exp_wr.push_back({16'h01FD, 8'h12});
        exp_wr.push_back({16'h01FC, 8'h34});
        exp_wr.push_back({16'h01FB, 8'h56});
        start(3'd2, 8'h12, 8'h34, 8'h56, acc);
        exp_done.push_back(mkd(acc + 4, 8'hFA));
        wait_done(20);

        // PULL2 (RTS) from FA.
        bd(8'hFB, 8'hAA);
        bd(8'hFC, 8'hBB);
        exp_rd.push_back({16'h01FB, 1'b0});
        exp_rd.push_back({16'h01FC, 1'b1});
        start(3'd4, 8'h00, 8'h00, 8'h00, acc);
        pb0 = 8'hAA; pb1 = 8'hBB;
        exp_done.push_back(mkd(acc + 4, 8'hFC));
        wait_done(20);

        // Wrap: push at 00, pull at FF.
        set_s(8'h00);
        exp_wr.push_back({16'h0100, 8'h77});
        start(3'd0, 8'h77, 8'h00, 8'h00, acc);
        exp_done.push_back(mkd(acc + 2, 8'hFF));
        wait_done(20);
        exp_rd.push_back({16'h0100, 1'b1});
        start(3'd3, 8'h00, 8'h00, 8'h00, acc);
        pb0 = 8'h77;
        exp_done.push_back(mkd(acc + 3, 8'h00));
        wait_done(20);

        // PUSH2 with a three-cycle stall starting in cycle 2.
        set_s(8'h80);
        exp_wr.push_back({16'h0180, 8'hA1});
        exp_wr.push_back({16'h017F, 8'hB2});
        start(3'd1, 8'hA1, 8'hB2, 8'h00, acc);
        exp_done.push_back(mkd(acc + 6, 8'h7E));
        @(negedge clk);
        ifc.mem_rdy = 1'b0;
        repeat (3) @(negedge clk);
        ifc.mem_rdy = 1'b1;
        wait_done(20);

        // TXS while busy is ignored, including in DONE.
        exp_wr.push_back({16'h017E, 8'h9C});
        start(3'd0, 8'h9C, 8'h00, 8'h00, acc);
        txs_load = 1'b1; x_in = 8'h33;
        exp_done.push_back(mkd(acc + 2, 8'h7D));
        @(negedge clk);
        push_snap(mk(1'b0, 2'd0, 8'h00, 1'b1, 1'b1));
        @(negedge clk);
        txs_load = 1'b0;

        // Invalid op 7 is ignored.
        @(negedge clk);
        ifc.req = 1'b1; ifc.op = 3'd7;
        push_snap(mk(1'b0, 2'd0, 8'h00, 1'b0, 1'b0));
        @(negedge clk);
        ifc.req = 1'b0;
        push_snap(mk(1'b0, 2'd0, 8'h00, 1'b0, 1'b0));
        @(negedge clk);
        push_snap(mk(1'b0, 2'd0, 8'h00, 1'b0, 1'b0));

        // Valid request and TXS together: request wins.
        set_s(8'h50);
        bd(8'h51, 8'h5A);
        exp_rd.push_back({16'h0151, 1'b1});
        @(negedge clk);
        ifc.req = 1'b1; ifc.op = 3'd3; txs_load = 1'b1; x_in = 8'h11;
        acc = cyc;
        push_snap(mk(1'b0, 2'd0, 8'h00, 1'b0, 1'b0));
        pb0 = 8'h5A;
        exp_done.push_back(mkd(acc + 3, 8'h51));
        @(negedge clk);
        ifc.req = 1'b0; txs_load = 1'b0;
        wait_done(20);

        // Reset in cycle 2 of PULL3.
        set_s(8'h20);
        bd(8'h21, 8'hE1);
        bd(8'h22, 8'hE2);
        bd(8'h23, 8'hE3);
        exp_rd.push_back({16'h0121, 1'b0});
        start(3'd5, 8'h00, 8'h00, 8'h00, acc);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pb0 = 8'h00; pb1 = 8'h00; pb2 = 8'h00;
        push_snap(mk(1'b0, 2'd0, 8'h00, 1'b0, 1'b0));
        repeat (3) begin
            @(negedge clk);
            push_snap(mk(1'b0, 2'd0, 8'h00, 1'b0, 1'b0));
        end
        exp_wr.push_back({16'h0122, 8'hC3});
        start(3'd0, 8'hC3, 8'h00, 8'h00, acc);
        exp_done.push_back(mkd(acc + 2, 8'h21));
        wait_done(20);

        repeat (3) @(negedge clk);
        fin = 1'b1;
        repeat (5) @(negedge clk);
        $display("FAIL finish_not_reached got no summary want summary");
        $fatal(1, "monitor did not finish");
    end

endmodule
